operand_entry_ctrl: RTL

//   Input side of the 8-bit calculator. It takes the 8 slide switches and two push buttons,

---
 rtl/operand_entry_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/operand_entry_ctrl.sv
// Operand entry front end for the 8-bit calculator.
// Buttons are synchronised, debounced and edge-detected; an FSM loads A and then B for fa_8.

module operand_entry_db #(
  parameter int DEBOUNCE_CNT = 100000,
  parameter int CNT_W        = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             s1, s2;
  logic             lvl, lvl_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      lvl   <= 1'b0;
      lvl_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      lvl_q <= lvl;
      // any return to the accepted level restarts the stability window
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        lvl <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign pulse = lvl & ~lvl_q;

endmodule

module operand_entry_ctrl #(
  parameter int DEBOUNCE_CNT = 100000,
  parameter int CNT_W        = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sw,
  input  logic       btn_enter,
  input  logic       btn_clear,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic       operands_valid,
  output logic [1:0] phase
);
  localparam int NUM_BTN = 2;
  localparam int BTN_ENTER = 0;
  localparam int BTN_CLEAR = 1;

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    DONE   = 2'b10
  } state_t;

  logic [7:0]         sw_s1, sw_sync;
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_p;
  logic               enter_p, clear_p;

  state_t     state, state_nxt;
  logic [7:0] a_nxt, b_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= sw;
      sw_sync <= sw_s1;
    end
  end

  assign btn_raw = {btn_clear, btn_enter};

  operand_entry_db #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .CNT_W        (CNT_W)
  ) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_raw),
    .pulse (btn_p)
  );

  assign enter_p = btn_p[BTN_ENTER];
  assign clear_p = btn_p[BTN_CLEAR];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WAIT_A;
      a     <= '0;
      b     <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
    end
  end

  // clear has priority so a coincident enter never loads anything
  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    b_nxt     = b;
    if (clear_p) begin
      state_nxt = WAIT_A;
      a_nxt     = '0;
      b_nxt     = '0;
    end else if (enter_p) begin
      unique case (state)
        WAIT_A: begin
          a_nxt     = sw_sync;
          state_nxt = WAIT_B;
        end
        WAIT_B: begin
          b_nxt     = sw_sync;
          state_nxt = DONE;
        end
        DONE: begin
          a_nxt     = sw_sync;
          state_nxt = WAIT_B;
        end
        default: state_nxt = WAIT_A;
      endcase
    end
  end

  assign phase          = state;
  assign operands_valid = (state == DONE);

  a_no_phase3: assert property (@(posedge clk) disable iff (reset) phase != 2'b11);

endmodule
